// File: rtl/rec_f32_to_ieee_unpacker.sv
// Recoded F32 (33b) to IEEE binary32 converter; normals/specials in one cycle,
// subnormals denormalized by an iterative STEP-bit right shifter.
module rec_f32_to_ieee_unpacker #(
  parameter int STEP = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [32:0] in_rec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_bits,
  output logic        out_subnormal
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] STEP5 = 5'(STEP);

  state_t      state, state_nx;
  logic [23:0] mant;
  logic [4:0]  rem;
  logic        sgn;

  logic        in_sgn;
  logic [8:0]  in_exp;
  logic [22:0] in_frac;
  logic [7:0]  norm_exp;
  logic [8:0]  d_raw;
  logic [4:0]  d_clamp;
  logic        is_sub;
  logic [31:0] load_bits;
  logic        accept;
  logic [4:0]  step_amt;
  logic [23:0] mant_shifted;
  logic        last_shift;

  assign in_sgn   = in_rec[32];
  assign in_exp   = in_rec[31:23];
  assign in_frac  = in_rec[22:0];
  // Bias difference taken modulo 256; only the low byte reaches the result.
  assign norm_exp = in_exp[7:0] - 8'h81;
  assign d_raw    = 9'h082 - in_exp;
  assign d_clamp  = (d_raw > 9'd24) ? 5'd24 : d_raw[4:0];

  always_comb begin
    is_sub    = 1'b0;
    load_bits = {in_sgn, norm_exp, in_frac};
    case (in_exp[8:6])
      3'b000:  load_bits = {in_sgn, 8'h00, 23'h0};
      3'b110:  load_bits = {in_sgn, 8'hFF, 23'h0};
      3'b111:  load_bits = {in_sgn, 8'hFF, in_frac};
      default: is_sub = (in_exp < 9'h082);
    endcase
  end

  assign in_ready     = (state == IDLE) && !flush;
  assign accept       = in_valid && in_ready;
  assign out_valid    = (state == DONE);
  assign step_amt     = (rem < STEP5) ? rem : STEP5;
  assign mant_shifted = mant >> step_amt;
  assign last_shift   = (rem <= STEP5);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = is_sub ? SHIFT : DONE;
      SHIFT:   if (last_shift) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mant          <= '0;
      rem           <= '0;
      sgn           <= 1'b0;
      out_bits      <= '0;
      out_subnormal <= 1'b0;
    end else if (!flush) begin
      if (accept) begin
        if (is_sub) begin
          mant <= {1'b1, in_frac};
          rem  <= d_clamp;
          sgn  <= in_sgn;
        end else begin
          out_bits      <= load_bits;
          out_subnormal <= 1'b0;
        end
      end else if (state == SHIFT) begin
        mant <= mant_shifted;
        rem  <= rem - step_amt;
        if (last_shift) begin
          out_bits      <= {sgn, 8'h00, mant_shifted[22:0]};
          out_subnormal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rec_f32_to_ieee_unpacker.sv
// Directed vector bench for rec_f32_to_ieee_unpacker (STEP=4 main instance,
// STEP=1 instance for shifter-width latency).
module tb_rec_f32_to_ieee_unpacker;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [32:0] in_rec = '0;
  logic        in_valid = 1'b0, in_valid1 = 1'b0;
  logic        out_ready = 1'b0, out_ready1 = 1'b0;
  logic        in_ready, in_ready1, out_valid, out_valid1;
  logic [31:0] out_bits, out_bits1;
  logic        out_subnormal, out_subnormal1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rec_f32_to_ieee_unpacker #(.STEP(4)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rec(in_rec),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .out_subnormal(out_subnormal)
  );

  rec_f32_to_ieee_unpacker #(.STEP(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_rec(in_rec),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_bits(out_bits1), .out_subnormal(out_subnormal1)
  );

  typedef struct {
    logic [32:0] rec;
    logic [31:0] bits;
    logic        sub;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [32:0] rec, input bit w1);
    @(negedge clock);
    chk("in_ready_before_issue", w1 ? in_ready1 : in_ready, 1);
    in_rec = rec;
    if (w1) in_valid1 = 1'b1; else in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
    in_rec    = 33'h1_5A5A_5A5A;
  endtask

  task automatic wait_out(input bit w1, output int lat);
    lat = 1;
    forever begin
      @(negedge clock);
      if ((w1 ? out_valid1 : out_valid) === 1'b1) break;
      lat++;
      if (lat > 60) break;
    end
  endtask

  task automatic release_out(input bit w1);
    if (w1) out_ready1 = 1'b1; else out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready  = 1'b0;
    out_ready1 = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit w1, input string tag);
    int lat;
    issue(v.rec, w1);
    wait_out(w1, lat);
    chk({tag, "_bits"}, w1 ? out_bits1 : out_bits, v.bits);
    chk({tag, "_sub"}, w1 ? out_subnormal1 : out_subnormal, v.sub);
    chk({tag, "_lat"}, lat, v.lat);
    release_out(w1);
  endtask

  vec_t vecs[14];

  initial begin
    int  lat;
    bit  seen;
    vec_t v;

    vecs[0]  = '{33'h0_8000_0000, 32'h3F80_0000, 1'b0, 1};
    vecs[1]  = '{33'h0_3580_0000, 32'h0000_0001, 1'b1, 7};
    vecs[2]  = '{33'h1_40FF_FFFF, 32'h807F_FFFF, 1'b1, 2};
    vecs[3]  = '{33'h0_C000_0000, 32'h7F80_0000, 1'b0, 1};
    vecs[4]  = '{33'h0_E040_0000, 32'h7FC0_0000, 1'b0, 1};
    vecs[5]  = '{33'h1_0000_0000, 32'h8000_0000, 1'b0, 1};
    vecs[6]  = '{33'h0_357F_FFFF, 32'h0000_0000, 1'b1, 7};
    vecs[7]  = '{33'h0_2812_3456, 32'h0000_0000, 1'b1, 7};
    vecs[8]  = '{33'h0_412A_AAAA, 32'h00AA_AAAA, 1'b0, 1};
    vecs[9]  = '{33'h1_BFFF_FFFF, 32'hFF7F_FFFF, 1'b0, 1};
    vecs[10] = '{33'h0_3F00_0000, 32'h0008_0000, 1'b1, 2};
    vecs[11] = '{33'h0_3EFF_FFFF, 32'h0007_FFFF, 1'b1, 3};
    vecs[12] = '{33'h0_3D00_000F, 32'h0000_8000, 1'b1, 3};
    vecs[13] = '{33'h0_1FFF_FFFF, 32'h0000_0000, 1'b0, 1};

    repeat (2) @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_out_sub", out_subnormal, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // STEP=1 instance: one bit per shift cycle
    run_vec(vecs[2], 1'b1, "step1_d1");
    v = '{33'h0_3580_0000, 32'h0000_0001, 1'b1, 24};
    run_vec(v, 1'b1, "step1_d23");

    // Backpressure hold in DONE
    issue(33'h1_40FF_FFFF, 1'b0);
    wait_out(1'b0, lat);
    chk("hold_lat", lat, 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("hold_valid", out_valid, 1);
      chk("hold_bits", out_bits, 32'h807F_FFFF);
      chk("hold_in_ready", in_ready, 0);
    end
    release_out(1'b0);
    @(negedge clock);
    chk("hold_released", out_valid, 0);

    // Flush two cycles into a long shift
    issue(33'h0_3580_0000, 1'b0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    chk("flush_pre_valid", out_valid, 0);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    @(posedge clock);
    #1;
    flush = 1'b0;
    @(negedge clock);
    chk("flush_idle", in_ready, 1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_output", seen, 0);

    // Flush concurrent with in_valid blocks acceptance
    @(negedge clock);
    in_rec = 33'h0_8000_0000;
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_blocks_ready", in_ready, 0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clock);
    chk("flush_not_accepted", out_valid, 0);
    run_vec(vecs[0], 1'b0, "post_flush");

    // Asynchronous reset mid-shift
    issue(33'h0_3580_0000, 1'b0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_bits", out_bits, 0);
    chk("arst_out_sub", out_subnormal, 0);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    chk("arst_no_output", seen, 0);
    run_vec(vecs[0], 1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
